// File: rtl/recv.sv
// recv: UART receive datapath, 16x oversampled, 5..9 data bits, parity, 1/2 stop.
// Optional macro RECV_MAJORITY_VOTE_EN: 3-sample majority vote at each sample point.
module recv #(
    parameter int SIZE_DATA     = 9,
    parameter int OVER_SAMPLING = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stick,
    input  logic                 i_rx_en,
    input  logic                 i_data_rx,
    input  logic [2:0]           i_size_frame,
    input  logic [1:0]           i_parity_bit,
    input  logic                 i_stop_bit,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_done_rx,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);
    localparam int CW = $clog2(OVER_SAMPLING);
    localparam logic [CW-1:0] MID  = CW'(OVER_SAMPLING / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVER_SAMPLING - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic          bit_s;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [3:0]    last_idx;
    logic [8:0]    data_r;
    logic          perr_r;
    logic          ferr_r;
    logic          stop_idx;
    logic [2:0]    size_q;
    logic [1:0]    par_q;
    logic          stop_q;
    logic          par_en;
    logic          par_odd;
    logic          par_bad;

    // two-flop synchroniser; idles high like the line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_data_rx;
            rx_s  <= sync1;
        end
    end

`ifdef RECV_MAJORITY_VOTE_EN
    logic [1:0] hist;

    // previous two stick samples for the majority vote
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist <= 2'b11;
        end else if (i_stick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign bit_s = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign bit_s = rx_s;
`endif

    // index of the last data bit for the latched frame size
    always_comb begin
        case (size_q)
            3'd0:    last_idx = 4'd4;
            3'd1:    last_idx = 4'd5;
            3'd2:    last_idx = 4'd6;
            3'd4:    last_idx = 4'd8;
            default: last_idx = 4'd7;
        endcase
    end

    assign par_en  = (par_q == 2'b01) || (par_q == 2'b10);
    assign par_odd = (par_q == 2'b01);
    assign par_bad = (^data_r) ^ bit_s ^ par_odd;

    // receive FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            armed        <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            data_r       <= '0;
            perr_r       <= 1'b0;
            ferr_r       <= 1'b0;
            stop_idx     <= 1'b0;
            size_q       <= '0;
            par_q        <= '0;
            stop_q       <= 1'b0;
            o_data       <= '0;
            o_done_rx    <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_done_rx <= 1'b0;
            if (state == IDLE && rx_s) begin
                armed <= 1'b1;
            end
            if (state != IDLE && !i_rx_en) begin
                state  <= IDLE;
                o_busy <= 1'b0;
                cnt    <= '0;
            end else if (i_stick) begin
                case (state)
                    IDLE: begin
                        if (i_rx_en && armed && !rx_s) begin
                            state    <= START;
                            o_busy   <= 1'b1;
                            armed    <= 1'b0;
                            cnt      <= '0;
                            data_r   <= '0;
                            perr_r   <= 1'b0;
                            ferr_r   <= 1'b0;
                            stop_idx <= 1'b0;
                            size_q   <= i_size_frame;
                            par_q    <= i_parity_bit;
                            stop_q   <= i_stop_bit;
                        end
                    end
                    START: begin
                        if (cnt == MID) begin
                            cnt <= '0;
                            if (!bit_s) begin
                                idx   <= '0;
                                state <= DATA;
                            end else begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            data_r[idx] <= bit_s;
                            idx         <= idx + 1'b1;
                            if (idx == last_idx) begin
                                state <= par_en ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            perr_r <= par_bad;
                            state  <= STOP;
                        end
                    end
                    STOP: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            if (!stop_q || stop_idx) begin
                                state        <= IDLE;
                                o_busy       <= 1'b0;
                                o_data       <= SIZE_DATA'(data_r);
                                o_parity_err <= perr_r;
                                o_frame_err  <= ferr_r | ~bit_s;
                                o_done_rx    <= 1'b1;
                            end else begin
                                stop_idx <= 1'b1;
                                ferr_r   <= ferr_r | ~bit_s;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_recv.sv
// tb_recv: frame-level reference model for recv; compares every done
// pulse against queued expectations and checks outputs hold otherwise.
module tb_recv;
    logic       clk;
    logic       rst_n;
    logic       stick;
    logic       rx_en;
    logic       rx;
    logic [2:0] size;
    logic [1:0] par;
    logic       stop2;
    logic [8:0] data;
    logic       done;
    logic       perr;
    logic       ferr;
    logic       busy;

    int checks;
    int failures;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];
    bit   mon_en;

    recv dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stick      (stick),
        .i_rx_en      (rx_en),
        .i_data_rx    (rx),
        .i_size_frame (size),
        .i_parity_bit (par),
        .i_stop_bit   (stop2),
        .o_data       (data),
        .o_done_rx    (done),
        .o_parity_err (perr),
        .o_frame_err  (ferr),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // stick once every 4 clocks
    initial begin
        stick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            stick = 1'b1;
            @(negedge clk);
            stick = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_sticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!stick) @(posedge clk);
        end
    endtask

    task automatic drive_line(input logic v, input int n);
        #1 rx = v;
        wait_sticks(n);
    endtask

    // model: expected word, parity and framing flags from the frame rules
    task automatic send_frame(input logic [8:0] d, input logic [2:0] sz,
                              input logic [1:0] pr, input logic st2,
                              input logic pb, input logic s1,
                              input logic s2);
        int         n;
        logic [8:0] dm;
        logic       x;
        exp_t       e;
        n    = (sz <= 3'd4) ? 5 + int'(sz) : 8;
        dm   = d & 9'((1 << n) - 1);
        x    = (^dm) ^ pb;
        e.d  = dm;
        e.pe = (pr == 2'b10) ? x : (pr == 2'b01) ? ~x : 1'b0;
        e.fe = !s1 || (st2 && !s2);
        q.push_back(e);
        #1;
        size  = sz;
        par   = pr;
        stop2 = st2;
        drive_line(1'b0, 16);
        size  = 3'($urandom);
        par   = 2'($urandom);
        stop2 = 1'($urandom);
        for (int i = 0; i < n; i++) drive_line(dm[i], 16);
        if (pr == 2'b01 || pr == 2'b10) drive_line(pb, 16);
        drive_line(s1, 16);
        if (st2) drive_line(s2, 16);
    endtask

    // compare process: done pulses against the model, holds otherwise
    initial begin
        exp_t       e;
        logic [8:0] ld;
        logic       lpe;
        logic       lfe;
        ld  = '0;
        lpe = 1'b0;
        lfe = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (done) begin
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_done actual=1 required=0 data=%0h",
                                 data);
                    end else begin
                        e = q.pop_front();
                        if (data !== e.d || perr !== e.pe || ferr !== e.fe) begin
                            failures++;
                            $display("FAIL frame actual d=%0h pe=%b fe=%b required d=%0h pe=%b fe=%b",
                                     data, perr, ferr, e.d, e.pe, e.fe);
                        end
                    end
                    ld  = data;
                    lpe = perr;
                    lfe = ferr;
                end else if (data !== ld || perr !== lpe || ferr !== lfe) begin
                    failures++;
                    $display("FAIL hold actual d=%0h pe=%b fe=%b required d=%0h pe=%b fe=%b",
                             data, perr, ferr, ld, lpe, lfe);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        rx_en    = 1'b0;
        rx       = 1'b1;
        size     = 3'd3;
        par      = 2'b00;
        stop2    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data", 32'(data), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_perr", 32'(perr), 0);
        chk("reset_ferr", 32'(ferr), 0);
        chk("reset_busy", 32'(busy), 0);
        rst_n  = 1'b1;
        rx_en  = 1'b1;
        mon_en = 1'b1;
        drive_line(1'b1, 32);

        send_frame(9'h0A5, 3'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("8n1_data", 32'(data), 32'h0A5);
        chk("8n1_perr", 32'(perr), 0);
        chk("8n1_ferr", 32'(ferr), 0);
        drive_line(1'b1, 8);

        send_frame(9'h041, 3'd2, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("7e1_data", 32'(data), 32'h041);
        chk("7e1_perr", 32'(perr), 1);
        chk("7e1_ferr", 32'(ferr), 0);
        drive_line(1'b1, 8);

        send_frame(9'h1FF, 3'd4, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("9o2_data", 32'(data), 32'h1FF);
        chk("9o2_perr", 32'(perr), 0);
        chk("9o2_ferr", 32'(ferr), 0);
        drive_line(1'b1, 8);

        send_frame(9'h0C3, 3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("break_data", 32'(data), 32'h0C3);
        chk("break_ferr", 32'(ferr), 1);
        drive_line(1'b0, 640);
        chk("break_idle", 32'(busy), 0);
        drive_line(1'b1, 32);

        size  = 3'd3;
        par   = 2'b00;
        stop2 = 1'b0;
        drive_line(1'b0, 4);
        chk("glitch_busy", 32'(busy), 1);
        drive_line(1'b1, 32);
        chk("glitch_idle", 32'(busy), 0);
        send_frame(9'h03C, 3'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("after_glitch_data", 32'(data), 32'h03C);
        drive_line(1'b1, 8);

        size  = 3'd3;
        par   = 2'b00;
        stop2 = 1'b0;
        drive_line(1'b0, 16);
        drive_line(1'b1, 16);
        chk("abort_busy_before", 32'(busy), 1);
        rx_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort_busy_after", 32'(busy), 0);
        drive_line(1'b1, 32);
        rx_en = 1'b1;
        drive_line(1'b1, 16);

        send_frame(9'h055, 3'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(9'h0AA, 3'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("b2b_data", 32'(data), 32'h0AA);
        drive_line(1'b1, 8);

        for (int k = 0; k < 25; k++) begin
            send_frame(9'($urandom), 3'($urandom), 2'($urandom),
                       1'($urandom), 1'($urandom),
                       ($urandom_range(0, 4) != 0),
                       ($urandom_range(0, 4) != 0));
            drive_line(1'b1, $urandom_range(1, 20));
        end

        drive_line(1'b1, 32);
        chk("pending_frames", 32'(q.size()), 0);
        chk("final_busy", 32'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
